// File: rtl/matrix_addsub_seq_pkg.sv
// Shared types, constants and the FP32 add helper for the matrix add/subtract datapath.
package matrix_addsub_seq_pkg;

  localparam int unsigned FP_WIDTH    = 32;
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_CALC = 2'd1,
    A_RDY  = 2'd2
  } add_state_t;

  // Flat element index for row r, column c.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned cols);
    return r * cols + c;
  endfunction

  // FP32 add, round-to-nearest-even; denormal inputs and underflowing results flush to signed zero.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0]  ea, eb, d;
    logic [23:0] ma, mb;
    logic [26:0] xa, xb;
    logic [27:0] s;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic [24:0] m;
    logic        rnd, found;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    ea = a[30:23];
    eb = b[30:23];
    if (ea == 8'hFF) begin
      if (a[22:0] != 23'd0 || (eb == 8'hFF && b[22:0] != 23'd0)) return FP_QNAN;
      if (eb == 8'hFF && a[31] != b[31]) return FP_QNAN;
      return a;
    end
    ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    d  = ea - eb;
    xa = {ma, 3'b000};
    if (d >= 8'd27) begin
      xb = {26'd0, (mb != 24'd0)};
    end else begin
      xb    = {mb, 3'b000} >> d;
      xb[0] = xb[0] | (|({mb, 3'b000} & ((27'd1 << d) - 27'd1)));
    end
    if (a[31] == b[31]) s = {1'b0, xa} + {1'b0, xb};
    else                s = {1'b0, xa} - {1'b0, xb};
    if (s == 28'd0) return (a[31] == b[31]) ? {a[31], 31'd0} : 32'd0;
    e = {2'b00, ea};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && s[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      s = s << lz;
      e = e - 10'(lz);
    end
    if (e[9] || e == 10'd0) return {a[31], 31'd0};
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + 25'(rnd);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {a[31], 8'hFF, 23'd0};
    return {a[31], e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/matrix_addsub_seq_adder.sv
// Shared multi-cycle FP32 adder core with load / result_ready / result_ack handshake.
module adder
  import matrix_addsub_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [FP_WIDTH-1:0] Number1,
  input  logic [FP_WIDTH-1:0] Number2,
  input  logic                result_ack,
  output logic                result_ready,
  output logic [FP_WIDTH-1:0] Result
);

  add_state_t          st, st_n;
  logic [FP_WIDTH-1:0] x, x_n, y, y_n, res_n;
  logic                ready_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= A_IDLE;
      x            <= '0;
      y            <= '0;
      Result       <= '0;
      result_ready <= 1'b0;
    end else begin
      st           <= st_n;
      x            <= x_n;
      y            <= y_n;
      Result       <= res_n;
      result_ready <= ready_n;
    end
  end

  always_comb begin
    st_n    = st;
    x_n     = x;
    y_n     = y;
    res_n   = Result;
    ready_n = result_ready;
    case (st)
      A_IDLE: begin
        if (load && !result_ack) begin
          x_n  = Number1;
          y_n  = Number2;
          st_n = A_CALC;
        end
      end
      A_CALC: begin
        res_n   = fp_add(x, y);
        ready_n = 1'b1;
        st_n    = A_RDY;
      end
      A_RDY: begin
        if (result_ack) begin
          ready_n = 1'b0;
          st_n    = A_IDLE;
        end
      end
      default: begin
        ready_n = 1'b0;
        st_n    = A_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// ROWS x COLS element-wise FP32 add/subtract, one shared adder time-multiplexed over all elements.
module matrix_addsub_seq
  import matrix_addsub_seq_pkg::*;
#(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 2,
  parameter int unsigned FPW  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     A_stb,
  input  logic                     B_stb,
  input  logic                     op_sub,
  input  logic [ROWS*COLS*FPW-1:0] A,
  input  logic [ROWS*COLS*FPW-1:0] B,
  output logic                     in_ack,
  output logic                     busy,
  output logic                     result_ready,
  input  logic                     result_ack,
  output logic [ROWS*COLS*FPW-1:0] result
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VW = N * FPW;

  state_t           st, st_n;
  logic [KW-1:0]    k, k_n;
  logic [FPW-1:0]   a_q [N];
  logic [FPW-1:0]   b_q [N];
  logic [FPW-1:0]   r_q [N];
  logic [FPW-1:0]   a_n [N];
  logic [FPW-1:0]   b_n [N];
  logic [FPW-1:0]   r_n [N];
  logic             sub_q, sub_n;
  logic [VW-1:0]    result_n;
  logic             in_ack_n, busy_n, ready_n;
  logic             add_load, add_load_n, add_ack, add_ack_n;
  logic [FPW-1:0]   add_n1, add_n1_n, add_n2, add_n2_n;
  logic             add_ready;
  logic [FPW-1:0]   add_res;

  adder u_adder (
    .clk          (clk),
    .reset        (reset),
    .load         (add_load),
    .Number1      (add_n1),
    .Number2      (add_n2),
    .result_ack   (add_ack),
    .result_ready (add_ready),
    .Result       (add_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= S_IDLE;
      k            <= '0;
      sub_q        <= 1'b0;
      result       <= '0;
      in_ack       <= 1'b0;
      busy         <= 1'b0;
      result_ready <= 1'b0;
      add_load     <= 1'b0;
      add_ack      <= 1'b0;
      add_n1       <= '0;
      add_n2       <= '0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      st           <= st_n;
      k            <= k_n;
      sub_q        <= sub_n;
      result       <= result_n;
      in_ack       <= in_ack_n;
      busy         <= busy_n;
      result_ready <= ready_n;
      add_load     <= add_load_n;
      add_ack      <= add_ack_n;
      add_n1       <= add_n1_n;
      add_n2       <= add_n2_n;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= a_n[i];
        b_q[i] <= b_n[i];
        r_q[i] <= r_n[i];
      end
    end
  end

  always_comb begin
    st_n       = st;
    k_n        = k;
    a_n        = a_q;
    b_n        = b_q;
    r_n        = r_q;
    sub_n      = sub_q;
    result_n   = result;
    in_ack_n   = 1'b0;
    busy_n     = busy;
    ready_n    = result_ready;
    add_load_n = 1'b0;
    add_ack_n  = add_ack;
    add_n1_n   = add_n1;
    add_n2_n   = add_n2;
    case (st)
      S_IDLE: begin
        if (A_stb && B_stb) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
              a_n[idx(r, c, COLS)] = A[idx(r, c, COLS)*FPW +: FPW];
              b_n[idx(r, c, COLS)] = B[idx(r, c, COLS)*FPW +: FPW];
            end
          end
          sub_n    = op_sub;
          in_ack_n = 1'b1;
          busy_n   = 1'b1;
          k_n      = '0;
          st_n     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Subtraction is addition with the B sign flipped, NaN included.
        add_n1_n              = a_q[k];
        add_n2_n              = b_q[k];
        add_n2_n[FP_SIGN_BIT] = b_q[k][FP_SIGN_BIT] ^ sub_q;
        add_load_n            = 1'b1;
        st_n                  = S_WAIT;
      end
      S_WAIT: begin
        if (add_ready) begin
          r_n[k]    = add_res;
          add_ack_n = 1'b1;
          st_n      = S_ACK;
        end
      end
      S_ACK: begin
        if (!add_ready) begin
          add_ack_n = 1'b0;
          if (k == KW'(N - 1)) begin
            for (int i = 0; i < N; i++) result_n[i*FPW +: FPW] = r_q[i];
            ready_n = 1'b1;
            st_n    = S_DONE;
          end else begin
            k_n  = k + KW'(1);
            st_n = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (result_ack) begin
          ready_n = 1'b0;
          busy_n  = 1'b0;
          st_n    = S_IDLE;
        end
      end
      default: begin
        st_n = S_IDLE;
      end
    endcase
  end

endmodule
